// File: rtl/video_stream_pkg.sv
// Shared types and constants for the Avalon-ST video test-pattern source
// and the stream filters that consume its frames.
package video_stream_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_CONST   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_HGRAD   = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_PIXELS = 2'd2,
    ST_GAP    = 2'd3
  } src_state_e;

  localparam logic [7:0] DEFAULT_HEADER_WORD = 8'h00;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/test_pattern_pixel.sv
// Combinational pixel generator: maps a pixel coordinate and the latched
// pattern selection to the 8-bit pixel value, truncated mod 256.
module test_pattern_pixel
  import video_stream_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int XW    = 2,
  parameter int YW    = 2
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  pattern_e      mode_i,
  input  logic [7:0]    const_i,
  output logic [7:0]    pixel_o
);

  logic [7:0] ramp_s;
  logic [7:0] checker_s;
  logic [7:0] hgrad_s;

  assign ramp_s    = 8'(32'(y_i) * 32'(WIDTH) + 32'(x_i) + 32'd1);
  assign checker_s = (x_i[0] ^ y_i[0]) ? 8'hFF : 8'h00;
  assign hgrad_s   = 8'(32'(x_i));

  // Pattern select
  always_comb begin
    pixel_o = 8'h00;
    case (mode_i)
      PAT_RAMP:    pixel_o = ramp_s;
      PAT_CONST:   pixel_o = const_i;
      PAT_CHECKER: pixel_o = checker_s;
      PAT_HGRAD:   pixel_o = hgrad_s;
      default:     pixel_o = ramp_s;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST video packet transmitter: one SOP header beat followed by
// WIDTH*HEIGHT row-major pixels per frame, honouring ready with latency 0.
module video_pattern_source
  import video_stream_pkg::*;
#(
  parameter int         WIDTH       = 4,
  parameter int         HEIGHT      = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [7:0] HEADER_WORD = DEFAULT_HEADER_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  mode,
  input  logic [7:0]  const_value,
  output logic [7:0]  data_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  localparam int XW = int'(cnt_width(WIDTH));
  localparam int YW = int'(cnt_width(HEIGHT));
  localparam int GW = int'(cnt_width(GAP_CYCLES));

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  src_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] gap_q, gap_d;
  pattern_e      mode_q, mode_d;
  logic [7:0]    const_q, const_d;
  logic          latch_s;

  logic [7:0]    data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [15:0]   frames_q, frames_d;

  logic          accept_s;
  logic          last_pix_s;
  logic [7:0]    pixel_s;

  assign accept_s   = valid_q && ready_in;
  assign last_pix_s = (x_q == X_LAST) && (y_q == Y_LAST);

  // FSM state, coordinate counters and per-frame pattern latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
      mode_q  <= PAT_RAMP;
      const_q <= 8'h00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      const_q <= const_d;
    end
  end

  // Next-state logic; every transition into HEADER also latches the pattern
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d = ST_HEADER;
          latch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (accept_s) begin
          state_d = ST_PIXELS;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_PIXELS: begin
        if (accept_s && last_pix_s) begin
          // Without a gap the restart decision is taken on the EOP accept
          if (GAP_CYCLES != 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else if (continuous) begin
            state_d = ST_HEADER;
            latch_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept_s) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + Y_ONE;
          end else begin
            x_d = x_q + X_ONE;
          end
        end else begin
          state_d = ST_PIXELS;
        end
      end
      ST_GAP: begin
        if (gap_q == G_LAST) begin
          if (continuous) begin
            state_d = ST_HEADER;
            latch_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + G_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (latch_s) begin
      mode_d  = pattern_e'(mode);
      const_d = const_value;
    end else begin
      mode_d  = mode_q;
      const_d = const_q;
    end
  end

  test_pattern_pixel #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW)
  ) u_pixel (
    .x_i     (x_d),
    .y_i     (y_d),
    .mode_i  (mode_d),
    .const_i (const_d),
    .pixel_o (pixel_s)
  );

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    valid_d = (state_d == ST_HEADER) || (state_d == ST_PIXELS);
    sop_d   = (state_d == ST_HEADER);
    eop_d   = (state_d == ST_PIXELS) && (x_d == X_LAST) && (y_d == Y_LAST);
    data_d  = 8'h00;
    case (state_d)
      ST_HEADER: data_d = HEADER_WORD;
      ST_PIXELS: data_d = pixel_s;
      default:   data_d = 8'h00;
    endcase
    done_d = accept_s && eop_q;
    if (done_d) begin
      frames_d = frames_q + 16'd1;
    end else begin
      frames_d = frames_q;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= 8'h00;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= 16'd0;
    end else begin
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      frames_q <= frames_d;
    end
  end

  assign data_out          = data_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out   = eop_q;
  assign valid_out         = valid_q;
  assign busy              = valid_q;
  assign frame_done        = done_q;
  assign frames_sent       = frames_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source: a 4x4 instance with a 2-cycle gap,
// a 4x4 instance with no gap and a 1x1 instance, all with hand-derived beats.
module tb_video_pattern_source;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] mode;
  logic [7:0] const_value;

  logic start_a, cont_a, ready_a;
  logic [7:0] data_a;
  logic sop_a, eop_a, valid_a, busy_a, done_a;
  logic [15:0] frames_a;

  logic start_b, cont_b, ready_b;
  logic [7:0] data_b;
  logic sop_b, eop_b, valid_b, busy_b, done_b;
  logic [15:0] frames_b;

  logic start_c, cont_c, ready_c;
  logic [7:0] data_c;
  logic sop_c, eop_c, valid_c, busy_c, done_c;
  logic [15:0] frames_c;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  video_pattern_source #(.WIDTH(4), .HEIGHT(4), .GAP_CYCLES(2), .HEADER_WORD(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start_a), .continuous(cont_a), .mode(mode),
    .const_value(const_value), .data_out(data_a), .startofpacket_out(sop_a),
    .endofpacket_out(eop_a), .valid_out(valid_a), .ready_in(ready_a), .busy(busy_a),
    .frame_done(done_a), .frames_sent(frames_a));

  video_pattern_source #(.WIDTH(4), .HEIGHT(4), .GAP_CYCLES(0), .HEADER_WORD(8'h00)) dut_g0 (
    .clk(clk), .reset(reset), .start(start_b), .continuous(cont_b), .mode(mode),
    .const_value(const_value), .data_out(data_b), .startofpacket_out(sop_b),
    .endofpacket_out(eop_b), .valid_out(valid_b), .ready_in(ready_b), .busy(busy_b),
    .frame_done(done_b), .frames_sent(frames_b));

  video_pattern_source #(.WIDTH(1), .HEIGHT(1), .GAP_CYCLES(2), .HEADER_WORD(8'h00)) dut_1x1 (
    .clk(clk), .reset(reset), .start(start_c), .continuous(cont_c), .mode(mode),
    .const_value(const_value), .data_out(data_c), .startofpacket_out(sop_c),
    .endofpacket_out(eop_c), .valid_out(valid_c), .ready_in(ready_c), .busy(busy_c),
    .frame_done(done_c), .frames_sent(frames_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; cont_b = 1'b0; ready_b = 1'b1;
    start_c = 1'b0; cont_c = 1'b0; ready_c = 1'b1;
    mode = 2'd0; const_value = 8'h00;
    repeat (3) tick();
    total++;
    if ({valid_a, sop_a, eop_a, done_a, busy_a} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags: got v/s/e/d/b=%b want 00000", {valid_a, sop_a, eop_a, done_a, busy_a});
    end
    total++;
    if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_a); end
    total++;
    if (frames_a !== 16'd0) begin bad++; $display("FAIL reset_frames: got %0d want 0", frames_a); end
    total++;
    if ({valid_b, valid_c} !== 2'b00) begin bad++; $display("FAIL reset_valid_bc: got %b want 00", {valid_b, valid_c}); end
    reset = 1'b1;
    repeat (2) tick();
    total++;
    if (valid_a !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got valid=%b want 0", valid_a); end
  endtask

  task automatic test_ramp();
    repeat (4) tick();
    mode = 2'd0; ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      total++;
      if (valid_a !== 1'b1 || data_a !== 8'(i) || sop_a !== (i == 0) || eop_a !== (i == 16) || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL ramp_beat%0d: got v=%b d=%h s=%b e=%b b=%b want v=1 d=%h s=%b e=%b b=1",
                 i, valid_a, data_a, sop_a, eop_a, busy_a, 8'(i), (i == 0), (i == 16));
      end
      tick();
    end
    exp_frames++;
    total++;
    if (valid_a !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++; $display("FAIL ramp_done: got v=%b done=%b busy=%b want 0 1 0", valid_a, done_a, busy_a);
    end
    total++;
    if (frames_a !== 16'(exp_frames)) begin bad++; $display("FAIL ramp_frames: got %0d want %0d", frames_a, exp_frames); end
    tick();
    total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL ramp_done_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    logic pv, pr, ps, pe;
    logic [7:0] pd;
    int beat, hold, cyc;
    pat = 32'hB3C5_6A1D;
    beat = 0; hold = 0; cyc = 0;
    pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pd = 8'h00;
    repeat (4) tick();
    mode = 2'd0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    while (beat < 17 && cyc < 300) begin
      if (pv && !pr) begin
        total++;
        if ({valid_a, sop_a, eop_a, data_a} !== {pv, ps, pe, pd}) begin
          bad++; $display("FAIL stall_hold: got v=%b s=%b e=%b d=%h want v=%b s=%b e=%b d=%h",
                          valid_a, sop_a, eop_a, data_a, pv, ps, pe, pd);
        end
      end
      if (valid_a && beat == 16 && hold < 10) begin
        ready_a = 1'b0;
        hold++;
        total++;
        if (eop_a !== 1'b1 || data_a !== 8'd16) begin
          bad++; $display("FAIL eop_hold: got e=%b d=%h want e=1 d=10", eop_a, data_a);
        end
      end else begin
        ready_a = pat[cyc % 32];
      end
      if (valid_a && ready_a) begin
        total++;
        if (data_a !== 8'(beat) || sop_a !== (beat == 0) || eop_a !== (beat == 16)) begin
          bad++; $display("FAIL bp_beat%0d: got d=%h s=%b e=%b want d=%h s=%b e=%b",
                          beat, data_a, sop_a, eop_a, 8'(beat), (beat == 0), (beat == 16));
        end
        beat++;
      end
      pv = valid_a; pr = ready_a; ps = sop_a; pe = eop_a; pd = data_a;
      tick();
      cyc++;
    end
    ready_a = 1'b1;
    total++;
    if (beat != 17) begin bad++; $display("FAIL bp_timeout: got %0d beats want 17", beat); end
    exp_frames++;
    total++;
    if (done_a !== 1'b1 || frames_a !== 16'(exp_frames)) begin
      bad++; $display("FAIL bp_done: got done=%b frames=%0d want 1 %0d", done_a, frames_a, exp_frames);
    end
  endtask

  task automatic test_continuous_checker();
    logic [7:0] chk [16];
    int n, low, vcount;
    chk = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00,
            8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
    repeat (4) tick();
    mode = 2'd2; ready_a = 1'b1; cont_a = 1'b1;
    n = 0;
    while (!(valid_a && sop_a) && n < 10) begin tick(); n++; end
    total++;
    if (!(valid_a && sop_a)) begin bad++; $display("FAIL cont_sop_timeout: got v=%b s=%b want 1 1", valid_a, sop_a); end
    for (int i = 0; i < 17; i++) begin
      total++;
      if (valid_a !== 1'b1 || data_a !== ((i == 0) ? 8'h00 : chk[(i == 0) ? 0 : i - 1]) || eop_a !== (i == 16)) begin
        bad++; $display("FAIL chk_f1_beat%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                        i, valid_a, data_a, eop_a, (i == 0) ? 8'h00 : chk[(i == 0) ? 0 : i - 1], (i == 16));
      end
      tick();
    end
    total++;
    if (done_a !== 1'b1) begin bad++; $display("FAIL chk_done: got %b want 1", done_a); end
    low = 0;
    while (!valid_a && low < 10) begin low++; tick(); end
    total++;
    if (low != 2 || sop_a !== 1'b1) begin
      bad++; $display("FAIL chk_gap: got %0d idle cycles sop=%b want 2 idle sop=1", low, sop_a);
    end
    cont_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      total++;
      if (valid_a !== 1'b1 || data_a !== ((i == 0) ? 8'h00 : chk[(i == 0) ? 0 : i - 1])) begin
        bad++; $display("FAIL chk_f2_beat%0d: got v=%b d=%h", i, valid_a, data_a);
      end
      tick();
    end
    exp_frames += 2;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a) vcount++;
      tick();
    end
    total++;
    if (vcount != 0) begin bad++; $display("FAIL cont_stop: got %0d valid cycles want 0", vcount); end
    total++;
    if (frames_a !== 16'(exp_frames)) begin bad++; $display("FAIL cont_frames: got %0d want %0d", frames_a, exp_frames); end
  endtask

  task automatic test_const_mode_change();
    repeat (4) tick();
    mode = 2'd1; const_value = 8'h5A; ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    total++;
    if (valid_a !== 1'b1 || sop_a !== 1'b1 || data_a !== 8'h00) begin
      bad++; $display("FAIL const_header: got v=%b s=%b d=%h want 1 1 00", valid_a, sop_a, data_a);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin mode = 2'd3; const_value = 8'h11; end
      total++;
      if (valid_a !== 1'b1 || data_a !== 8'h5A) begin
        bad++; $display("FAIL const_pix%0d: got v=%b d=%h want v=1 d=5a", i, valid_a, data_a);
      end
      tick();
    end
    exp_frames++;
    repeat (4) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    total++;
    if (valid_a !== 1'b1 || sop_a !== 1'b1) begin bad++; $display("FAIL hgrad_header: got v=%b s=%b want 1 1", valid_a, sop_a); end
    tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (valid_a !== 1'b1 || data_a !== 8'(i % 4)) begin
        bad++; $display("FAIL hgrad_pix%0d: got v=%b d=%h want v=1 d=%h", i, valid_a, data_a, 8'(i % 4));
      end
      tick();
    end
    exp_frames++;
    total++;
    if (frames_a !== 16'(exp_frames)) begin bad++; $display("FAIL hgrad_frames: got %0d want %0d", frames_a, exp_frames); end
  endtask

  task automatic test_start_busy();
    int vcount;
    repeat (4) tick();
    mode = 2'd0; ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    vcount = 0;
    for (int c = 1; c <= 40; c++) begin
      if (valid_a) vcount++;
      start_a = (c == 5 || c == 17 || c == 18 || c == 19);
      tick();
    end
    start_a = 1'b0;
    exp_frames++;
    total++;
    if (vcount != 17) begin bad++; $display("FAIL start_busy_beats: got %0d want 17", vcount); end
    total++;
    if (frames_a !== 16'(exp_frames)) begin bad++; $display("FAIL start_busy_frames: got %0d want %0d", frames_a, exp_frames); end
  endtask

  task automatic test_reset_midframe();
    int n;
    repeat (4) tick();
    mode = 2'd0; ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!(valid_a && data_a == 8'd7) && n < 20) begin tick(); n++; end
    total++;
    if (!(valid_a && data_a == 8'd7)) begin bad++; $display("FAIL rst_pix7_timeout: got d=%h want 07", data_a); end
    reset = 1'b0;
    #1;
    total++;
    if ({valid_a, sop_a, eop_a, busy_a} !== 4'b0000 || data_a !== 8'h00) begin
      bad++; $display("FAIL rst_abort: got v/s/e/b=%b d=%h want 0000 00", {valid_a, sop_a, eop_a, busy_a}, data_a);
    end
    total++;
    if (frames_a !== 16'd0) begin bad++; $display("FAIL rst_frames: got %0d want 0", frames_a); end
    exp_frames = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    total++;
    if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_no_resume: got valid=%b want 0", valid_a); end
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      total++;
      if (valid_a !== 1'b1 || data_a !== 8'(i) || sop_a !== (i == 0)) begin
        bad++; $display("FAIL rst_restart_beat%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                        i, valid_a, data_a, sop_a, 8'(i), (i == 0));
      end
      tick();
    end
    exp_frames++;
    total++;
    if (frames_a !== 16'(exp_frames)) begin bad++; $display("FAIL rst_restart_frames: got %0d want %0d", frames_a, exp_frames); end
  endtask

  task automatic test_gap0();
    int n;
    repeat (2) tick();
    mode = 2'd0; ready_b = 1'b1; cont_b = 1'b1;
    n = 0;
    while (!(valid_b && sop_b) && n < 10) begin tick(); n++; end
    total++;
    if (!(valid_b && sop_b)) begin bad++; $display("FAIL g0_sop_timeout: got v=%b s=%b want 1 1", valid_b, sop_b); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (valid_b !== 1'b1 || eop_b !== 1'b0) begin bad++; $display("FAIL g0_f1_beat%0d: got v=%b e=%b want 1 0", i, valid_b, eop_b); end
      tick();
    end
    total++;
    if (valid_b !== 1'b1 || eop_b !== 1'b1 || data_b !== 8'd16) begin
      bad++; $display("FAIL g0_eop: got v=%b e=%b d=%h want 1 1 10", valid_b, eop_b, data_b);
    end
    tick();
    total++;
    if (valid_b !== 1'b1 || sop_b !== 1'b1 || done_b !== 1'b1) begin
      bad++; $display("FAIL g0_back_to_back: got v=%b s=%b done=%b want 1 1 1", valid_b, sop_b, done_b);
    end
    cont_b = 1'b0;
    repeat (17) tick();
    total++;
    if (valid_b !== 1'b0 || done_b !== 1'b1 || frames_b !== 16'd2) begin
      bad++; $display("FAIL g0_stop: got v=%b done=%b frames=%0d want 0 1 2", valid_b, done_b, frames_b);
    end
  endtask

  task automatic test_one_by_one();
    repeat (2) tick();
    mode = 2'd0; ready_c = 1'b1;
    start_c = 1'b1; tick(); start_c = 1'b0;
    total++;
    if ({valid_c, sop_c, eop_c} !== 3'b110 || data_c !== 8'h00) begin
      bad++; $display("FAIL 1x1_header: got v/s/e=%b d=%h want 110 00", {valid_c, sop_c, eop_c}, data_c);
    end
    tick();
    total++;
    if ({valid_c, sop_c, eop_c} !== 3'b101 || data_c !== 8'h01) begin
      bad++; $display("FAIL 1x1_pixel: got v/s/e=%b d=%h want 101 01", {valid_c, sop_c, eop_c}, data_c);
    end
    tick();
    total++;
    if (valid_c !== 1'b0 || done_c !== 1'b1 || frames_c !== 16'd1) begin
      bad++; $display("FAIL 1x1_done: got v=%b done=%b frames=%0d want 0 1 1", valid_c, done_c, frames_c);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_continuous_checker();
    test_const_mode_change();
    test_start_busy();
    test_reset_midframe();
    test_gap0();
    test_one_by_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
